// File: rtl/cfg_pkg.sv
// Shared types and constants for the FSIC configuration AXI-Lite scheduler.
package cfg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RESP    = 3'd4
  } state_e;

  localparam int NUM_TGT = 5;

  localparam int TGT_UP = 0;
  localparam int TGT_LA = 1;
  localparam int TGT_AA = 2;
  localparam int TGT_IS = 3;
  localparam int TGT_AS = 4;

  localparam logic [19:0] PAGE_UP = 20'h30000;
  localparam logic [19:0] PAGE_LA = 20'h30001;
  localparam logic [19:0] PAGE_AA = 20'h30002;
  localparam logic [19:0] PAGE_IS = 20'h30003;
  localparam logic [19:0] PAGE_AS = 20'h30004;

  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

  // Maps a 4 KB page number to a one-hot target enable; zero means no target.
  function automatic logic [NUM_TGT-1:0] decode_tgt(input logic [19:0] page);
    logic [NUM_TGT-1:0] en;
    en = 5'b00000;
    case (page)
      PAGE_UP: en[TGT_UP] = 1'b1;
      PAGE_LA: en[TGT_LA] = 1'b1;
      PAGE_AA: en[TGT_AA] = 1'b1;
      PAGE_IS: en[TGT_IS] = 1'b1;
      PAGE_AS: en[TGT_AS] = 1'b1;
      default: en = 5'b00000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/cfg_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the port that did not win last time is granted.
module cfg_rr_arb2
  import cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;
  logic [1:0] grant_s;

  // Grant selection and last-winner update on every accept
  always_comb begin
    grant_s      = 2'b00;
    last_grant_d = last_grant_q;
    if (en) begin
      case (req)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
    if (grant_s != 2'b00) begin
      last_grant_d = grant_s[1];
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Reset to port 1 so that port 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/cfg_axil_sched.sv
// Shares one AXI-Lite config master between two requesters, one transaction at a time,
// with target window decode and per-phase timeout.
module cfg_axil_sched
  import cfg_pkg::*;
#(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 255
) (
  input  logic                     axi_clk,
  input  logic                     axi_rst,
  input  logic [1:0]               req_valid,
  input  logic [1:0]               req_we,
  input  logic [31:0]              req_addr0,
  input  logic [31:0]              req_addr1,
  input  logic [pDATA_WIDTH-1:0]   req_wdata0,
  input  logic [pDATA_WIDTH-1:0]   req_wdata1,
  input  logic [pDATA_WIDTH/8-1:0] req_wstrb0,
  input  logic [pDATA_WIDTH/8-1:0] req_wstrb1,
  output logic [1:0]               req_ready,
  output logic [1:0]               rsp_valid,
  output logic [pDATA_WIDTH-1:0]   rsp_rdata,
  output logic                     rsp_err,
  output logic                     axi_awvalid,
  output logic [pADDR_WIDTH-1:0]   axi_awaddr,
  input  logic                     axi_awready,
  output logic                     axi_wvalid,
  output logic [pDATA_WIDTH-1:0]   axi_wdata,
  output logic [pDATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                     axi_wready,
  output logic                     axi_arvalid,
  output logic [pADDR_WIDTH-1:0]   axi_araddr,
  input  logic                     axi_arready,
  input  logic                     axi_rvalid,
  input  logic [pDATA_WIDTH-1:0]   axi_rdata,
  output logic                     axi_rready,
  output logic [NUM_TGT-1:0]       tgt_en
);

  localparam logic [7:0] TMO_LIMIT = 8'(pTIMEOUT);
  localparam logic [pDATA_WIDTH-1:0] ERR_DATA = {pDATA_WIDTH{1'b1}};
  localparam logic [pDATA_WIDTH-1:0] ZERO_DATA = {pDATA_WIDTH{1'b0}};

  state_e state_q, state_d;
  logic                     port_q, port_d;
  logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [pDATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [pDATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [NUM_TGT-1:0]       tgt_en_q, tgt_en_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic [7:0]               tmo_q, tmo_d;
  logic [1:0]               rsp_valid_q, rsp_valid_d;
  logic [pDATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_err_q, rsp_err_d;

  logic [1:0]               grant_s;
  logic                     sel_port_s;
  logic                     sel_we_s;
  logic [31:0]              sel_addr_s;
  logic [NUM_TGT-1:0]       sel_tgt_s;
  logic [1:0]               port_oh_s;
  logic [7:0]               tmo_inc_s;
  logic                     tmo_hit_s;
  logic                     aw_done_n_s;
  logic                     w_done_n_s;

  cfg_rr_arb2 u_arb (
    .clk   (axi_clk),
    .rst   (axi_rst),
    .en    (state_q == IDLE),
    .req   (req_valid),
    .grant (grant_s)
  );

  assign sel_port_s  = grant_s[1];
  assign sel_we_s    = sel_port_s ? req_we[1] : req_we[0];
  assign sel_addr_s  = sel_port_s ? req_addr1 : req_addr0;
  assign sel_tgt_s   = decode_tgt(sel_addr_s[31:12]);
  assign port_oh_s   = {port_q, ~port_q};
  assign tmo_inc_s   = tmo_q + 8'd1;
  assign tmo_hit_s   = (tmo_inc_s == TMO_LIMIT);
  assign aw_done_n_s = aw_done_q | (awvalid_q & axi_awready);
  assign w_done_n_s  = w_done_q | (wvalid_q & axi_wready);

  // Transaction sequencing: next state, channel handshakes and response capture
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    tgt_en_d    = tgt_en_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    tmo_d       = tmo_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (grant_s != 2'b00) begin
          port_d    = sel_port_s;
          addr_d    = sel_addr_s[pADDR_WIDTH-1:0];
          wdata_d   = sel_port_s ? req_wdata1 : req_wdata0;
          wstrb_d   = sel_port_s ? req_wstrb1 : req_wstrb0;
          tgt_en_d  = sel_tgt_s;
          tmo_d     = 8'd0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (sel_tgt_s == 5'b00000) begin
            state_d     = RESP;
            rsp_valid_d = grant_s;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = sel_we_s ? ZERO_DATA : ERR_DATA;
          end else if (sel_we_s) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        awvalid_d = awvalid_q & ~axi_awready;
        wvalid_d  = wvalid_q & ~axi_wready;
        aw_done_d = aw_done_n_s;
        w_done_d  = w_done_n_s;
        if (aw_done_n_s && w_done_n_s) begin
          state_d     = RESP;
          tmo_d       = 8'd0;
          rsp_valid_d = port_oh_s;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = ZERO_DATA;
        end else if (tmo_hit_s) begin
          state_d     = RESP;
          tmo_d       = 8'd0;
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          rsp_valid_d = port_oh_s;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = ERR_DATA;
        end else begin
          tmo_d = tmo_inc_s;
        end
      end
      RD_ADDR: begin
        if (axi_arready) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_d     = 8'd0;
        end else if (tmo_hit_s) begin
          state_d     = RESP;
          arvalid_d   = 1'b0;
          tmo_d       = 8'd0;
          rsp_valid_d = port_oh_s;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = ERR_DATA;
        end else begin
          tmo_d = tmo_inc_s;
        end
      end
      RD_DATA: begin
        if (axi_rvalid) begin
          state_d     = RESP;
          rready_d    = 1'b0;
          tmo_d       = 8'd0;
          rsp_valid_d = port_oh_s;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = axi_rdata;
        end else if (tmo_hit_s) begin
          state_d     = RESP;
          rready_d    = 1'b0;
          tmo_d       = 8'd0;
          rsp_valid_d = port_oh_s;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = ERR_DATA;
        end else begin
          tmo_d = tmo_inc_s;
        end
      end
      RESP: begin
        state_d     = IDLE;
        tgt_en_d    = 5'b00000;
        rsp_rdata_d = ZERO_DATA;
        rsp_err_d   = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        tgt_en_d  = 5'b00000;
      end
    endcase
  end

  // State and output registers; reset drops every valid immediately
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      tgt_en_q    <= 5'b00000;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      tmo_q       <= 8'd0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      tgt_en_q    <= tgt_en_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready   = grant_s;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = addr_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = addr_q;
  assign axi_rready  = rready_q;
  assign tgt_en      = tgt_en_q;

endmodule

// File: tb/tb_cfg_axil_sched.sv
// Directed bench for cfg_axil_sched: hand-computed expectations checked at mid-cycle.
module tb_cfg_axil_sched;

  logic        axi_clk;
  logic        axi_rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [31:0] req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [3:0]  req_wstrb0, req_wstrb1;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        axi_awvalid;
  logic [14:0] axi_awaddr;
  logic        axi_awready;
  logic        axi_wvalid;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wready;
  logic        axi_arvalid;
  logic [14:0] axi_araddr;
  logic        axi_arready;
  logic        axi_rvalid;
  logic [31:0] axi_rdata;
  logic        axi_rready;
  logic [4:0]  tgt_en;

  int n_cmp = 0;
  int n_err = 0;

  cfg_axil_sched dut (
    .axi_clk     (axi_clk),
    .axi_rst     (axi_rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr0   (req_addr0),
    .req_addr1   (req_addr1),
    .req_wdata0  (req_wdata0),
    .req_wdata1  (req_wdata1),
    .req_wstrb0  (req_wstrb0),
    .req_wstrb1  (req_wstrb1),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .axi_awvalid (axi_awvalid),
    .axi_awaddr  (axi_awaddr),
    .axi_awready (axi_awready),
    .axi_wvalid  (axi_wvalid),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wready  (axi_wready),
    .axi_arvalid (axi_arvalid),
    .axi_araddr  (axi_araddr),
    .axi_arready (axi_arready),
    .axi_rvalid  (axi_rvalid),
    .axi_rdata   (axi_rdata),
    .axi_rready  (axi_rready),
    .tgt_en      (tgt_en)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  task automatic tick();
    @(negedge axi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    axi_rst     = 1'b1;
    req_valid   = 2'b00;
    req_we      = 2'b00;
    req_addr0   = 32'h0;
    req_addr1   = 32'h0;
    req_wdata0  = 32'h0;
    req_wdata1  = 32'h0;
    req_wstrb0  = 4'h0;
    req_wstrb1  = 4'h0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = 32'h0;

    // reset state
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_awvalid", 32'(axi_awvalid), 32'h0);
    chk("rst_arvalid", 32'(axi_arvalid), 32'h0);
    chk("rst_tgt_en", 32'(tgt_en), 32'h0);
    axi_rst = 1'b0;
    tick();

    // port 0 write, immediate readies
    axi_awready = 1'b1;
    axi_wready  = 1'b1;
    req_valid   = 2'b01;
    req_we      = 2'b01;
    req_addr0   = 32'h3000_2010;
    req_wdata0  = 32'hA5A5_0001;
    req_wstrb0  = 4'hF;
    #1;
    chk("wr0_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    chk("wr0_awvalid", 32'(axi_awvalid), 32'h1);
    chk("wr0_wvalid", 32'(axi_wvalid), 32'h1);
    chk("wr0_awaddr", 32'(axi_awaddr), 32'h2010);
    chk("wr0_wdata", axi_wdata, 32'hA5A5_0001);
    chk("wr0_tgt_en", 32'(tgt_en), 32'h04);
    chk("wr0_no_rsp_yet", 32'(rsp_valid), 32'h0);
    tick();
    chk("wr0_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr0_rsp_err", 32'(rsp_err), 32'h0);
    chk("wr0_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr0_awvalid_drop", 32'(axi_awvalid), 32'h0);
    tick();
    chk("wr0_rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("wr0_tgt_clear", 32'(tgt_en), 32'h0);

    // port 1 read with arready delayed three cycles
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    req_valid   = 2'b10;
    req_we      = 2'b00;
    req_addr1   = 32'h3000_1004;
    #1;
    chk("rd1_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b01;
    req_we    = 2'b01;
    #1;
    chk("busy_not_ready", 32'(req_ready), 32'h0);
    chk("rd1_arvalid", 32'(axi_arvalid), 32'h1);
    chk("rd1_araddr", 32'(axi_araddr), 32'h1004);
    chk("rd1_tgt_en", 32'(tgt_en), 32'h02);
    tick();
    chk("rd1_arvalid_hold2", 32'(axi_arvalid), 32'h1);
    tick();
    chk("rd1_arvalid_hold3", 32'(axi_arvalid), 32'h1);
    req_valid   = 2'b00;
    axi_arready = 1'b1;
    tick();
    axi_arready = 1'b0;
    chk("rd1_arvalid_drop", 32'(axi_arvalid), 32'h0);
    chk("rd1_rready", 32'(axi_rready), 32'h1);
    axi_rvalid = 1'b1;
    axi_rdata  = 32'h1234_5678;
    tick();
    axi_rvalid = 1'b0;
    chk("rd1_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("rd1_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd1_rsp_err", 32'(rsp_err), 32'h0);
    chk("rd1_rready_drop", 32'(axi_rready), 32'h0);
    tick();
    chk("rd1_rsp_pulse", 32'(rsp_valid), 32'h0);

    // both ports request continuously: grants alternate starting at port 0
    axi_awready = 1'b1;
    axi_wready  = 1'b1;
    req_we      = 2'b11;
    req_addr0   = 32'h3000_2000;
    req_addr1   = 32'h3000_1000;
    req_wdata0  = 32'h0000_00A0;
    req_wdata1  = 32'h0000_00B1;
    req_valid   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = ((k % 2) == 0) ? 2'b01 : 2'b10;
      #1;
      chk("rr_grant", 32'(req_ready), 32'(exp_g));
      tick();
      chk("rr_wdata", axi_wdata, ((k % 2) == 0) ? 32'h0000_00A0 : 32'h0000_00B1);
      tick();
      chk("rr_rsp_port", 32'(rsp_valid), 32'(exp_g));
      tick();
    end
    req_valid = 2'b00;

    // decode misses: read returns all ones, write returns zero, no AXI activity
    req_valid = 2'b01;
    req_we    = 2'b00;
    req_addr0 = 32'h3000_7000;
    #1;
    chk("miss_rd_ready", 32'(req_ready), 32'h1);
    tick();
    chk("miss_rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("miss_rd_err", 32'(rsp_err), 32'h1);
    chk("miss_rd_rdata", rsp_rdata, 32'hFFFF_FFFF);
    chk("miss_rd_no_ar", 32'(axi_arvalid), 32'h0);
    chk("miss_rd_tgt", 32'(tgt_en), 32'h0);
    req_valid = 2'b00;
    tick();
    req_valid = 2'b10;
    req_we    = 2'b10;
    req_addr1 = 32'h4000_0000;
    #1;
    chk("miss_wr_ready", 32'(req_ready), 32'h2);
    tick();
    chk("miss_wr_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("miss_wr_err", 32'(rsp_err), 32'h1);
    chk("miss_wr_rdata", rsp_rdata, 32'h0);
    chk("miss_wr_no_aw", 32'(axi_awvalid), 32'h0);
    req_valid = 2'b00;
    tick();

    // write timeout: wready never comes
    axi_awready = 1'b1;
    axi_wready  = 1'b0;
    req_valid   = 2'b01;
    req_we      = 2'b01;
    req_addr0   = 32'h3000_3000;
    #1;
    chk("tmo_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    chk("tmo_wvalid_c1", 32'(axi_wvalid), 32'h1);
    chk("tmo_tgt_en", 32'(tgt_en), 32'h08);
    tick();
    chk("tmo_awvalid_c2", 32'(axi_awvalid), 32'h0);
    chk("tmo_wvalid_c2", 32'(axi_wvalid), 32'h1);
    repeat (253) tick();
    chk("tmo_wvalid_c255", 32'(axi_wvalid), 32'h1);
    chk("tmo_no_rsp_c255", 32'(rsp_valid), 32'h0);
    tick();
    chk("tmo_wvalid_drop", 32'(axi_wvalid), 32'h0);
    chk("tmo_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("tmo_rsp_err", 32'(rsp_err), 32'h1);
    chk("tmo_rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
    tick();

    // normal service after the timeout
    axi_wready = 1'b1;
    req_valid  = 2'b10;
    req_we     = 2'b10;
    req_addr1  = 32'h3000_4000;
    req_wdata1 = 32'hDEAD_0004;
    req_wstrb1 = 4'h3;
    #1;
    chk("post_tmo_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    chk("post_tmo_tgt_en", 32'(tgt_en), 32'h10);
    chk("post_tmo_wstrb", 32'(axi_wstrb), 32'h3);
    tick();
    chk("post_tmo_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("post_tmo_rsp_err", 32'(rsp_err), 32'h0);
    tick();

    // reset asserted while in RD_DATA
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    req_valid   = 2'b01;
    req_we      = 2'b00;
    req_addr0   = 32'h3000_0000;
    #1;
    chk("rstmid_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    chk("rstmid_arvalid", 32'(axi_arvalid), 32'h1);
    chk("rstmid_tgt_en", 32'(tgt_en), 32'h01);
    axi_arready = 1'b1;
    tick();
    axi_arready = 1'b0;
    chk("rstmid_rready", 32'(axi_rready), 32'h1);
    #1;
    axi_rst = 1'b1;
    #1;
    chk("rstmid_rready_async", 32'(axi_rready), 32'h0);
    chk("rstmid_arvalid_async", 32'(axi_arvalid), 32'h0);
    chk("rstmid_tgt_async", 32'(tgt_en), 32'h0);
    tick();
    chk("rstmid_no_rsp", 32'(rsp_valid), 32'h0);
    tick();
    axi_rst = 1'b0;
    tick();

    // after reset the tie goes to port 0 again
    axi_arready = 1'b1;
    axi_rvalid  = 1'b1;
    axi_rdata   = 32'hCAFE_0001;
    req_we      = 2'b00;
    req_addr0   = 32'h3000_0010;
    req_addr1   = 32'h3000_4010;
    req_valid   = 2'b11;
    #1;
    chk("post_rst_tie", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    chk("post_rst_araddr", 32'(axi_araddr), 32'h0010);
    tick();
    chk("post_rst_rready", 32'(axi_rready), 32'h1);
    tick();
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_rdata", rsp_rdata, 32'hCAFE_0001);
    chk("post_rst_err", 32'(rsp_err), 32'h0);
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
